// File: rtl/aes_key_sched.sv
// aes_key_sched: iterative AES key expansion for AES-128/192/256 (NK = 4/6/8).
// Produces one 32-bit schedule word per cycle from a sliding window of NK words
// and streams 128-bit round keys over a valid/ready handshake.
// Optional feature macro: AES_KS_DEC_EN adds the dec input and an (NR+1)x128
// round-key store so the schedule can be replayed in reverse (decryption) order.
//
// state | meaning
// IDLE  | waiting for start, busy low
// LOAD  | copying cipher-key word w[i] (i < NK) into the current 4-word group
// GEN   | computing w[i] = w[i-NK] ^ temp; words needing SubWord go via SUB
// SUB   | registered S-box result available, word written this cycle
// HOLD  | round key presented (rk_valid), waiting for rk_ready
module aes_key_sched #(
  parameter int NK    = 8,
  parameter int IDX_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef AES_KS_DEC_EN
  input  logic              dec,
`endif
  input  logic [32*NK-1:0]  key,
  output logic              busy,
  output logic              rk_valid,
  input  logic              rk_ready,
  output logic [127:0]      rk,
  output logic [IDX_W-1:0]  rk_idx,
  output logic              rk_last
);

  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);
  localparam logic [5:0]       I_LAST  = 6'(NW - 1);
  localparam logic [5:0]       I_NK    = 6'(NK);
  localparam logic [2:0]       KM_LAST = 3'(NK - 1);
  localparam logic [IDX_W-1:0] IDX_NR  = IDX_W'(NR);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_GEN, S_SUB, S_HOLD} state_t;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] base;
    base = {~b, 3'b111};
    return SBOX_TBL[base -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  state_t             state_q;
  logic [31:0]        win_q [NK];
  logic [31:0]        grp_q [3];
  logic [31:0]        sub_q;
  logic [7:0]         rcon_q;
  logic [5:0]         i_q;
  logic [2:0]         kmod_q;
  logic               busy_q;
  logic               valid_q;
  logic [127:0]       rk_q;
  logic [IDX_W-1:0]   idx_q;
  logic               last_q;

  logic               dec_mode;
  logic [127:0]       rev_rk;

  logic [31:0]        w_prev;
  logic [31:0]        w_old;
  logic [31:0]        sub_in;
  logic [31:0]        sub_d;
  logic [31:0]        new_word;
  logic               need_sub;
  logic               wr_word;
  logic               grp_done;
  logic [127:0]       full_grp;
  logic [5:0]         i_d;
  logic [2:0]         kmod_d;
  state_t             resume_st;

`ifdef AES_KS_DEC_EN
  logic               dec_q;
  logic [127:0]       store_q [NR+1];

  // Reverse-order source: the key one round below the one currently presented.
  always_comb begin
    dec_mode = dec_q;
    rev_rk   = store_q[idx_q - IDX_ONE];
  end

  // Round-key store, written as each group completes (contents only read after a full refill).
  always_ff @(posedge clk) begin
    if (!rst && grp_done) begin
      store_q[idx_q] <= full_grp;
    end
  end
`else
  // Forward-only build: no reverse replay path.
  always_comb begin
    dec_mode = 1'b0;
    rev_rk   = '0;
  end
`endif

  // Next schedule word: window head is w[i-NK], window tail is w[i-1].
  always_comb begin
    w_prev   = win_q[NK-1];
    w_old    = win_q[0];
    need_sub = (kmod_q == 3'd0) || ((NK == 8) && (kmod_q == 3'd4));
    sub_in   = (kmod_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    sub_d    = sub_word(sub_in);
    new_word = '0;
    wr_word  = 1'b0;
    case (state_q)
      S_LOAD: begin
        new_word = w_old;
        wr_word  = 1'b1;
      end
      S_GEN: begin
        if (!need_sub) begin
          new_word = w_old ^ w_prev;
          wr_word  = 1'b1;
        end
      end
      S_SUB: begin
        new_word = w_old ^ sub_q ^ ((kmod_q == 3'd0) ? {rcon_q, 24'h0} : 32'h0);
        wr_word  = 1'b1;
      end
      default: ;
    endcase
    grp_done  = wr_word && (i_q[1:0] == 2'd3);
    full_grp  = {grp_q[0], grp_q[1], grp_q[2], new_word};
    i_d       = i_q + 6'd1;
    kmod_d    = (kmod_q == KM_LAST) ? 3'd0 : kmod_q + 3'd1;
    resume_st = (i_d < I_NK) ? S_LOAD : S_GEN;
  end

  // Main sequencer: state, window, group assembly and registered stream outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      rk_q    <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      i_q     <= '0;
      kmod_q  <= '0;
      rcon_q  <= 8'h01;
      sub_q   <= '0;
      for (int k = 0; k < 3; k++) grp_q[k] <= '0;
      for (int k = 0; k < NK; k++) win_q[k] <= '0;
`ifdef AES_KS_DEC_EN
      dec_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            for (int k = 0; k < NK; k++) win_q[k] <= key[32*(NK-k)-1 -: 32];
            i_q     <= '0;
            kmod_q  <= '0;
            rcon_q  <= 8'h01;
            idx_q   <= '0;
            last_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_LOAD;
`ifdef AES_KS_DEC_EN
            dec_q   <= dec;
`endif
          end
        end
        S_GEN: begin
          if (need_sub) begin
            sub_q   <= sub_d;
            state_q <= S_SUB;
          end
        end
        S_HOLD: begin
          if (rk_ready) begin
            if (dec_mode) begin
              if (idx_q == '0) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                valid_q <= 1'b0;
                last_q  <= 1'b0;
              end else begin
                idx_q  <= idx_q - IDX_ONE;
                rk_q   <= rev_rk;
                last_q <= (idx_q == IDX_ONE);
              end
            end else if (idx_q == IDX_NR) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
            end else begin
              idx_q   <= idx_q + IDX_ONE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              state_q <= (i_q < I_NK) ? S_LOAD : S_GEN;
            end
          end
        end
        default: ;
      endcase

      if (wr_word) begin
        for (int k = 0; k < NK-1; k++) win_q[k] <= win_q[k+1];
        win_q[NK-1] <= new_word;
        case (i_q[1:0])
          2'd0: grp_q[0] <= new_word;
          2'd1: grp_q[1] <= new_word;
          2'd2: grp_q[2] <= new_word;
          default: ;
        endcase
        i_q    <= i_d;
        kmod_q <= kmod_d;
        if ((state_q == S_SUB) && (kmod_q == 3'd0)) begin
          rcon_q <= xtime(rcon_q);
        end
        if (grp_done) begin
          // In reverse mode intermediate groups only go to the store.
          if (dec_mode && (i_q != I_LAST)) begin
            idx_q   <= idx_q + IDX_ONE;
            state_q <= resume_st;
          end else begin
            rk_q    <= full_grp;
            valid_q <= 1'b1;
            last_q  <= !dec_mode && (idx_q == IDX_NR);
            state_q <= S_HOLD;
          end
        end else begin
          state_q <= resume_st;
        end
      end
    end
  end

  assign busy     = busy_q;
  assign rk_valid = valid_q;
  assign rk       = rk_q;
  assign rk_idx   = idx_q;
  assign rk_last  = last_q;

endmodule

// File: tb/tb_aes_key_sched.sv
// Bench for aes_key_sched: three instances (NK = 4, 6, 8) checked every cycle
// against a textbook key-expansion model built from GF(2^8) arithmetic.
`timescale 1ns/1ps
module tb_aes_key_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          rk_ready;
  logic          start_i [3];
  logic          dec_i   [3];
  logic [255:0]  keyv    [3];
  logic          busy_o  [3];
  logic          valid_o [3];
  logic [127:0]  rk_o    [3];
  logic [3:0]    idx_o   [3];
  logic          last_o  [3];

  aes_key_sched #(.NK(4), .IDX_W(4)) u_nk4 (
    .clk(clk), .rst(rst), .start(start_i[0]),
`ifdef AES_KS_DEC_EN
    .dec(dec_i[0]),
`endif
    .key(keyv[0][127:0]), .busy(busy_o[0]), .rk_valid(valid_o[0]), .rk_ready(rk_ready),
    .rk(rk_o[0]), .rk_idx(idx_o[0]), .rk_last(last_o[0]));

  aes_key_sched #(.NK(6), .IDX_W(4)) u_nk6 (
    .clk(clk), .rst(rst), .start(start_i[1]),
`ifdef AES_KS_DEC_EN
    .dec(dec_i[1]),
`endif
    .key(keyv[1][191:0]), .busy(busy_o[1]), .rk_valid(valid_o[1]), .rk_ready(rk_ready),
    .rk(rk_o[1]), .rk_idx(idx_o[1]), .rk_last(last_o[1]));

  aes_key_sched #(.NK(8), .IDX_W(4)) u_nk8 (
    .clk(clk), .rst(rst), .start(start_i[2]),
`ifdef AES_KS_DEC_EN
    .dec(dec_i[2]),
`endif
    .key(keyv[2]), .busy(busy_o[2]), .rk_valid(valid_o[2]), .rk_ready(rk_ready),
    .rk(rk_o[2]), .rk_idx(idx_o[2]), .rk_last(last_o[2]));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int rdy_mode = 0;

  logic [7:0]   sb [256];
  logic [127:0] mk [15];
  int           ml [15];

  bit           active  [3];
  bit           dec_run [3];
  bit           seen    [3];
  bit           post_rst[3];
  int           ptr     [3];
  int           n_exp   [3];
  int           ref_cyc [3];
  logic [127:0] e_rk   [3][15];
  logic [3:0]   e_idx  [3][15];
  logic         e_last [3][15];
  int           e_lat  [3][15];

  localparam logic [255:0] K4 = 256'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] K6 = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K8 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int d, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %h, expected %h", nm, d, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] t;
    t = {v, v} << n;
    return t[15:8];
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  // Textbook expansion into mk[], plus per-group cycle latency into ml[].
  task automatic gen_keys(input int nk, input logic [255:0] k);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nr, nw;
    nr = nk + 6;
    nw = 4 * (nr + 1);
    rc = 8'h01;
    for (int j = 0; j < nk; j++) w[j] = k[32*(nk-1-j) +: 32];
    for (int j = nk; j < nw; j++) begin
      t = w[j-1];
      if (j % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && j % nk == 4) begin
        t = subw(t);
      end
      w[j] = w[j-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) begin
      mk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      ml[r] = 4;
      for (int j = 4*r; j < 4*r+4; j++)
        if (j >= nk && (j % nk == 0 || (nk > 6 && j % nk == 4))) ml[r]++;
    end
  endtask

  task automatic build_exp(input int d, input logic dc);
    int nr;
    nr = 4 + 2*d + 6;
    gen_keys(4 + 2*d, keyv[d]);
    n_exp[d] = nr + 1;
    for (int r = 0; r <= nr; r++) begin
      if (!dc) begin
        e_rk[d][r]   = mk[r];
        e_idx[d][r]  = 4'(r);
        e_last[d][r] = (r == nr);
        e_lat[d][r]  = ml[r];
      end else begin
        e_rk[d][r]   = mk[nr-r];
        e_idx[d][r]  = 4'(nr-r);
        e_last[d][r] = (nr-r == 0);
        e_lat[d][r]  = 0;
      end
    end
  endtask

  // Per-cycle check of one instance, then advance its model to the next edge.
  task automatic check_dut(input int d);
    bit was_active;
    was_active = active[d];
    if (post_rst[d]) begin
      post_rst[d] = 0;
      chk("rst_busy",  d, 128'(busy_o[d]),  128'(0));
      chk("rst_valid", d, 128'(valid_o[d]), 128'(0));
      chk("rst_rk",    d, rk_o[d],          128'(0));
      chk("rst_idx",   d, 128'(idx_o[d]),   128'(0));
      chk("rst_last",  d, 128'(last_o[d]),  128'(0));
    end
    chk("busy", d, 128'(busy_o[d]), 128'(active[d]));
    if (valid_o[d] === 1'b1) begin
      if (!active[d] || ptr[d] >= n_exp[d]) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_key dut%0d: got rk_valid=1 idx=%0d, expected no key", d, idx_o[d]);
      end else begin
        chk("rk",      d, rk_o[d],          e_rk[d][ptr[d]]);
        chk("rk_idx",  d, 128'(idx_o[d]),   128'(e_idx[d][ptr[d]]));
        chk("rk_last", d, 128'(last_o[d]),  128'(e_last[d][ptr[d]]));
        if (!seen[d]) begin
          seen[d] = 1;
          if (!dec_run[d]) chk("latency", d, 128'(cyc - ref_cyc[d]), 128'(e_lat[d][ptr[d]]));
        end
      end
    end
    if (rst) begin
      active[d]   = 0;
      post_rst[d] = 1;
      ptr[d]      = 0;
      seen[d]     = 0;
    end else begin
      if (valid_o[d] === 1'b1 && rk_ready && active[d] && ptr[d] < n_exp[d]) begin
        ptr[d]++;
        seen[d]    = 0;
        ref_cyc[d] = cyc + 1;
        if (ptr[d] == n_exp[d]) active[d] = 0;
      end
      if (start_i[d] && !was_active) begin
        build_exp(d, dec_i[d]);
        dec_run[d] = dec_i[d];
        active[d]  = 1;
        ptr[d]     = 0;
        seen[d]    = 0;
        ref_cyc[d] = cyc + 1;
      end
    end
  endtask

  initial begin : compare
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) check_dut(d);
    end
  end

  // rk_ready: tied high, or 50% random with occasional runs of 10 low cycles.
  initial begin : ready_drv
    int run;
    run = 0;
    rk_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) rk_ready = 1'b1;
      else if (run > 0) begin
        rk_ready = 1'b0;
        run--;
      end else if ($urandom_range(0, 15) == 0) begin
        rk_ready = 1'b0;
        run = 9;
      end else rk_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic do_start(input int d, input logic [255:0] k, input logic dc);
    @(posedge clk);
    #1;
    keyv[d]    = k;
    dec_i[d]   = dc;
    start_i[d] = 1'b1;
    @(posedge clk);
    #1;
    start_i[d] = 1'b0;
    dec_i[d]   = 1'b0;
  endtask

  task automatic wait_done(input int d);
    int t;
    t = 0;
    while (active[d] && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (active[d]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout dut%0d: got %0d keys, expected %0d", d, ptr[d], n_exp[d]);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
    end
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [255:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin : main
    int t;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      start_i[d] = 1'b0;
      dec_i[d]   = 1'b0;
      keyv[d]    = '0;
    end
    build_sbox();

    gen_keys(4, K4);
    chk("model_nk4_r0",  0, mk[0],  128'h2b7e151628aed2a6abf7158809cf4f3c);
    chk("model_nk4_r1",  0, mk[1],  128'ha0fafe1788542cb123a339392a6c7605);
    chk("model_nk4_r10", 0, mk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("model_nk4_lat1", 0, 128'(ml[1]), 128'(5));
    gen_keys(6, K6);
    chk("model_nk6_r12", 1, mk[12], 128'he98ba06f448c773c8ecc720401002202);
    gen_keys(8, K8);
    chk("model_nk8_r14", 2, mk[14], 128'hfe4890d1e6188d0b046df344706c631e);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);

    rdy_mode = 0;
    do_start(0, K4, 1'b0); wait_done(0);
    do_start(1, K6, 1'b0); wait_done(1);
    do_start(2, K8, 1'b0); wait_done(2);

    rdy_mode = 1;
    do_start(2, K8, 1'b0); wait_done(2);

    // Abort at round 5, with start colliding with rst, then a clean restart.
    rdy_mode = 0;
    do_start(0, K4, 1'b0);
    t = 0;
    while (!(valid_o[0] === 1'b1 && idx_o[0] == 4'd5) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("reached_r5", 0, 128'(idx_o[0]), 128'(5));
    @(posedge clk);
    #1;
    rst = 1'b1;
    start_i[0] = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    start_i[0] = 1'b0;
    repeat (3) @(negedge clk);
    do_start(0, K4, 1'b0);
    repeat (6) @(posedge clk);
    do_start(0, rand_key(), 1'b0);
    wait_done(0);

    for (int it = 0; it < 6; it++) begin
      rdy_mode = int'($urandom_range(0, 1));
      do_start(it % 3, rand_key(), 1'b0);
      wait_done(it % 3);
    end

`ifdef AES_KS_DEC_EN
    rdy_mode = 0;
    do_start(0, K4, 1'b1); wait_done(0);
    do_start(0, K4, 1'b0); wait_done(0);
    for (int it = 0; it < 3; it++) begin
      rdy_mode = 1;
      do_start(it, rand_key(), 1'b1);
      wait_done(it);
    end
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
